// File: rtl/mbtrain_repair_ctrl_pkg.sv
// Shared message codes and FSM state types for the MBTRAIN REPAIR-step controller.
package mbtrain_repair_ctrl_pkg;

  localparam int unsigned MSG_W_DEF = 4;

  localparam logic [3:0] MSG_NONE         = 4'd0;
  localparam logic [3:0] MSG_INIT_REQ     = 4'd1;
  localparam logic [3:0] MSG_INIT_RESP    = 4'd2;
  localparam logic [3:0] MSG_DEGRADE_REQ  = 4'd3;
  localparam logic [3:0] MSG_DEGRADE_RESP = 4'd4;
  localparam logic [3:0] MSG_END_REQ      = 4'd5;
  localparam logic [3:0] MSG_END_RESP     = 4'd6;

  typedef enum logic [3:0] {
    TxIdle,
    TxSInitReq,
    TxWInitResp,
    TxSDegReq,
    TxWDegResp,
    TxSEndReq,
    TxWEndResp,
    TxDone,
    TxErr
  } tx_state_e;

  typedef enum logic [3:0] {
    RxIdle,
    RxWInitReq,
    RxSInitResp,
    RxWDegReq,
    RxSDegResp,
    RxWEndReq,
    RxSEndResp,
    RxDone,
    RxErr
  } rx_state_e;

endpackage

// File: rtl/mbtrain_repair_ctrl_sb_send_arbiter.sv
// Sideband send arbiter: RX-priority single grant per cycle, busy-lock between sends,
// registered send strobe and message.
module mbtrain_repair_ctrl_sb_send_arbiter #(
  parameter int unsigned MSG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tx_req,
  input  logic [MSG_W-1:0] tx_code,
  input  logic             rx_req,
  input  logic [MSG_W-1:0] rx_code,
  input  logic             busy_fall,
  output logic             tx_gnt,
  output logic             rx_gnt,
  output logic             valid,
  output logic [MSG_W-1:0] message
);

  logic lock_q;
  logic can_grant;

  // A falling busy edge in the same cycle unlocks immediately.
  assign can_grant = en && (!lock_q || busy_fall);
  assign rx_gnt    = can_grant && rx_req;
  assign tx_gnt    = can_grant && tx_req && !rx_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q  <= 1'b0;
      valid   <= 1'b0;
      message <= '0;
    end else if (!en) begin
      lock_q  <= 1'b0;
      valid   <= 1'b0;
      message <= '0;
    end else begin
      valid <= rx_gnt || tx_gnt;
      if (rx_gnt) begin
        message <= rx_code;
      end else if (tx_gnt) begin
        message <= tx_code;
      end else begin
        message <= '0;
      end
      if (rx_gnt || tx_gnt) begin
        lock_q <= 1'b1;
      end else if (busy_fall) begin
        lock_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mbtrain_repair_ctrl.sv
// MBTRAIN REPAIR-step controller: TX advertises the local group mask, RX captures
// the partner mask, with per-wait timeout and shared sideband send arbitration.
module mbtrain_repair_ctrl
  import mbtrain_repair_ctrl_pkg::*;
#(
  parameter int unsigned N_GROUPS       = 2,
  parameter int unsigned MSG_W          = MSG_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 8000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic [MSG_W-1:0]    i_sideband_message,
  input  logic [N_GROUPS-1:0] i_sideband_data_lanes_encoding,
  input  logic                i_rx_msg_valid,
  input  logic                i_falling_edge_busy,
  input  logic [N_GROUPS-1:0] i_lane_group_ok,
  output logic                o_valid,
  output logic [MSG_W-1:0]    o_sideband_message,
  output logic [N_GROUPS-1:0] o_sideband_data_lanes_encoding,
  output logic [N_GROUPS-1:0] o_remote_group_ok,
  output logic                o_test_ack,
  output logic                o_timeout_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  tx_state_e           tx_q;
  rx_state_e           rx_q;
  logic [TW-1:0]       tx_tmr_q, rx_tmr_q;
  logic [N_GROUPS-1:0] enc_q, remote_q;
  logic                ack_q, err_q;

  logic             tx_req, rx_req, tx_gnt, rx_gnt;
  logic             tx_wait, rx_wait, tx_hit, rx_hit, tx_to, rx_to, timeout;
  logic [3:0]       tx_send, rx_send, tx_exp, rx_exp;

  always_comb begin
    tx_req  = 1'b0;
    tx_wait = 1'b0;
    tx_send = MSG_NONE;
    tx_exp  = MSG_NONE;
    unique case (tx_q)
      TxSInitReq:  begin tx_req  = 1'b1; tx_send = MSG_INIT_REQ;     end
      TxWInitResp: begin tx_wait = 1'b1; tx_exp  = MSG_INIT_RESP;    end
      TxSDegReq:   begin tx_req  = 1'b1; tx_send = MSG_DEGRADE_REQ;  end
      TxWDegResp:  begin tx_wait = 1'b1; tx_exp  = MSG_DEGRADE_RESP; end
      TxSEndReq:   begin tx_req  = 1'b1; tx_send = MSG_END_REQ;      end
      TxWEndResp:  begin tx_wait = 1'b1; tx_exp  = MSG_END_RESP;     end
      default: ;
    endcase
  end

  always_comb begin
    rx_req  = 1'b0;
    rx_wait = 1'b0;
    rx_send = MSG_NONE;
    rx_exp  = MSG_NONE;
    unique case (rx_q)
      RxWInitReq:  begin rx_wait = 1'b1; rx_exp  = MSG_INIT_REQ;     end
      RxSInitResp: begin rx_req  = 1'b1; rx_send = MSG_INIT_RESP;    end
      RxWDegReq:   begin rx_wait = 1'b1; rx_exp  = MSG_DEGRADE_REQ;  end
      RxSDegResp:  begin rx_req  = 1'b1; rx_send = MSG_DEGRADE_RESP; end
      RxWEndReq:   begin rx_wait = 1'b1; rx_exp  = MSG_END_REQ;      end
      RxSEndResp:  begin rx_req  = 1'b1; rx_send = MSG_END_RESP;     end
      default: ;
    endcase
  end

  assign tx_hit  = tx_wait && i_rx_msg_valid && (i_sideband_message == MSG_W'(tx_exp));
  assign rx_hit  = rx_wait && i_rx_msg_valid && (i_sideband_message == MSG_W'(rx_exp));
  // A matching message in the final cycle still counts as a response.
  assign tx_to   = tx_wait && !tx_hit && (tx_tmr_q == TLAST);
  assign rx_to   = rx_wait && !rx_hit && (rx_tmr_q == TLAST);
  assign timeout = tx_to || rx_to;

  mbtrain_repair_ctrl_sb_send_arbiter #(
    .MSG_W(MSG_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (i_en),
    .tx_req   (tx_req && !timeout),
    .tx_code  (MSG_W'(tx_send)),
    .rx_req   (rx_req && !timeout),
    .rx_code  (MSG_W'(rx_send)),
    .busy_fall(i_falling_edge_busy),
    .tx_gnt   (tx_gnt),
    .rx_gnt   (rx_gnt),
    .valid    (o_valid),
    .message  (o_sideband_message)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q     <= TxIdle;
      rx_q     <= RxIdle;
      tx_tmr_q <= '0;
      rx_tmr_q <= '0;
      enc_q    <= '0;
      remote_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (!i_en) begin
      tx_q     <= TxIdle;
      rx_q     <= RxIdle;
      tx_tmr_q <= '0;
      rx_tmr_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (timeout) begin
      tx_q     <= TxErr;
      rx_q     <= RxErr;
      tx_tmr_q <= '0;
      rx_tmr_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b1;
    end else begin
      ack_q    <= (tx_q == TxDone) && (rx_q == RxDone);
      tx_tmr_q <= '0;
      rx_tmr_q <= '0;
      if (tx_wait && !tx_hit) tx_tmr_q <= tx_tmr_q + 1'b1;
      if (rx_wait && !rx_hit) rx_tmr_q <= rx_tmr_q + 1'b1;

      case (tx_q)
        TxIdle:      tx_q <= TxSInitReq;
        TxSInitReq:  if (tx_gnt) tx_q <= TxWInitResp;
        TxWInitResp: if (tx_hit) tx_q <= TxSDegReq;
        TxSDegReq:   if (tx_gnt) tx_q <= TxWDegResp;
        TxWDegResp:  if (tx_hit) tx_q <= TxSEndReq;
        TxSEndReq:   if (tx_gnt) tx_q <= TxWEndResp;
        TxWEndResp:  if (tx_hit) tx_q <= TxDone;
        default: ;
      endcase

      case (rx_q)
        RxIdle:      rx_q <= RxWInitReq;
        RxWInitReq:  if (rx_hit) rx_q <= RxSInitResp;
        RxSInitResp: if (rx_gnt) rx_q <= RxWDegReq;
        RxWDegReq:   if (rx_hit) rx_q <= RxSDegResp;
        RxSDegResp:  if (rx_gnt) rx_q <= RxWEndReq;
        RxWEndReq:   if (rx_hit) rx_q <= RxSEndResp;
        RxSEndResp:  if (rx_gnt) rx_q <= RxDone;
        default: ;
      endcase

      // An all-zero partner mask is captured like any other.
      if (rx_hit && (rx_q == RxWDegReq)) remote_q <= i_sideband_data_lanes_encoding;
      if (tx_gnt && (tx_q == TxSDegReq)) enc_q <= i_lane_group_ok;
    end
  end

  assign o_sideband_data_lanes_encoding = enc_q;
  assign o_remote_group_ok              = remote_q;
  assign o_test_ack                     = ack_q;
  assign o_timeout_err                  = err_q;

endmodule

// File: tb/tb_mbtrain_repair_ctrl.sv
// Directed bench: cycle table for the full handshake plus hand sequences for
// arbitration, timeout, zero mask, abort/restart, wide masks and async reset.
module tb_mbtrain_repair_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] msg = 4'd0;
  logic [3:0] enc_in = 4'd0;
  logic       rxv = 1'b0;
  logic       fall = 1'b0;
  logic [3:0] lane_ok = 4'b0011;

  logic       v2, ack2, err2;
  logic [3:0] m2;
  logic [1:0] enc2, rem2;
  logic       v4, ack4, err4;
  logic [3:0] m4;
  logic [3:0] enc4, rem4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mbtrain_repair_ctrl #(
    .N_GROUPS(2), .MSG_W(4), .TIMEOUT_CYCLES(16)
  ) dut2 (
    .clk(clk), .rst(rst), .i_en(en),
    .i_sideband_message(msg),
    .i_sideband_data_lanes_encoding(enc_in[1:0]),
    .i_rx_msg_valid(rxv),
    .i_falling_edge_busy(fall),
    .i_lane_group_ok(lane_ok[1:0]),
    .o_valid(v2),
    .o_sideband_message(m2),
    .o_sideband_data_lanes_encoding(enc2),
    .o_remote_group_ok(rem2),
    .o_test_ack(ack2),
    .o_timeout_err(err2)
  );

  mbtrain_repair_ctrl #(
    .N_GROUPS(4), .MSG_W(4), .TIMEOUT_CYCLES(16)
  ) dut4 (
    .clk(clk), .rst(rst), .i_en(en),
    .i_sideband_message(msg),
    .i_sideband_data_lanes_encoding(enc_in),
    .i_rx_msg_valid(rxv),
    .i_falling_edge_busy(fall),
    .i_lane_group_ok(lane_ok),
    .o_valid(v4),
    .o_sideband_message(m4),
    .o_sideband_data_lanes_encoding(enc4),
    .o_remote_group_ok(rem4),
    .o_test_ack(ack4),
    .o_timeout_err(err4)
  );

  typedef struct {
    logic       en;
    logic [3:0] msg;
    logic [1:0] enc;
    logic       rxv;
    logic       fall;
    logic       e_valid;
    logic [3:0] e_msg;
    logic [1:0] e_enc;
    logic [1:0] e_rem;
    logic       e_ack;
    logic       e_err;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] m, input logic v, input logic f);
    msg  = m;
    rxv  = v;
    fall = f;
    tick();
    msg  = 4'd0;
    rxv  = 1'b0;
    fall = 1'b0;
  endtask

  // Abort then re-enable: both FSMs start over from IDLE.
  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
  endtask

  initial begin
    bit saw_valid;
    bit saw_err;

    tbl[0]  = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd1, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'd1, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd2, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'd2, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd3, 2'd3, 2'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'd3, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd3, 2'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd3, 2'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd4, 2'd3, 2'd1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'd4, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd3, 2'd1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd5, 2'd3, 2'd1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 4'd5, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd3, 2'd1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd6, 2'd3, 2'd1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 4'd6, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd3, 2'd1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd3, 2'd1, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd3, 2'd1, 1'b1, 1'b0};

    #1 rst = 1'b1;
    #12 rst = 1'b0;
    #1;
    chk("reset valid", 32'(v2), 32'd0);
    chk("reset msg", 32'(m2), 32'd0);
    chk("reset ack/err", 32'({ack2, err2}), 32'd0);
    chk("reset masks", 32'({enc2, rem2}), 32'd0);
    tick();

    // Full handshake, cycle by cycle.
    for (int i = 0; i < 20; i++) begin
      en     = tbl[i].en;
      msg    = tbl[i].msg;
      enc_in = {2'b00, tbl[i].enc};
      rxv    = tbl[i].rxv;
      fall   = tbl[i].fall;
      tick();
      chk($sformatf("t1[%0d] valid", i), 32'(v2), 32'(tbl[i].e_valid));
      chk($sformatf("t1[%0d] msg", i), 32'(m2), 32'(tbl[i].e_msg));
      chk($sformatf("t1[%0d] enc", i), 32'(enc2), 32'(tbl[i].e_enc));
      chk($sformatf("t1[%0d] remote", i), 32'(rem2), 32'(tbl[i].e_rem));
      chk($sformatf("t1[%0d] ack", i), 32'(ack2), 32'(tbl[i].e_ack));
      chk($sformatf("t1[%0d] err", i), 32'(err2), 32'(tbl[i].e_err));
    end
    msg = 4'd0; rxv = 1'b0; fall = 1'b0; enc_in = 4'd0;

    // Contention: both engines waiting behind the busy-lock; RX goes first.
    restart();
    tick();
    chk("t2 init_req", 32'({v2, m2}), 32'h11);
    drive(4'd2, 1'b1, 1'b0);
    chk("t2 locked a", 32'(v2), 32'd0);
    drive(4'd1, 1'b1, 1'b0);
    chk("t2 locked b", 32'(v2), 32'd0);
    tick();
    chk("t2 locked c", 32'(v2), 32'd0);
    drive(4'd0, 1'b0, 1'b1);
    chk("t2 rx first", 32'({v2, m2}), 32'h12);
    tick();
    chk("t2 tx held", 32'(v2), 32'd0);
    drive(4'd0, 1'b0, 1'b1);
    chk("t2 tx after fall", 32'({v2, m2}), 32'h13);

    // Abort in W_DEG_RESP, then restart.
    restart();
    tick();
    chk("t5 init_req", 32'({v2, m2}), 32'h11);
    drive(4'd2, 1'b1, 1'b1);
    tick();
    chk("t5 deg_req", 32'({v2, m2}), 32'h13);
    en = 1'b0;
    tick();
    chk("t5 abort valid", 32'({v2, ack2, err2}), 32'd0);
    chk("t5 remote kept", 32'(rem2), 32'd1);
    en = 1'b1;
    tick();
    chk("t5 restart idle", 32'(v2), 32'd0);
    tick();
    chk("t5 restart init_req", 32'({v2, m2}), 32'h11);

    // Timeout: no INIT_RESP from the partner.
    restart();
    tick();
    chk("t3 init_req", 32'({v2, m2}), 32'h11);
    drive(4'd1, 1'b1, 1'b1);
    tick();
    chk("t3 init_resp", 32'({v2, m2}), 32'h12);
    saw_valid = 1'b0;
    saw_err   = 1'b0;
    for (int k = 3; k < 16; k++) begin
      tick();
      if (v2) saw_valid = 1'b1;
      if (err2) saw_err = 1'b1;
    end
    chk("t3 quiet before timeout", 32'({saw_valid, saw_err}), 32'd0);
    tick();
    chk("t3 timeout at 16", 32'({err2, v2}), 32'h2);
    drive(4'd2, 1'b1, 1'b1);
    tick();
    chk("t3 err sticky", 32'({err2, v2}), 32'h2);
    en = 1'b0;
    tick();
    chk("t3 err cleared", 32'(err2), 32'd0);

    // Partner advertises an all-zero mask.
    restart();
    tick();
    chk("t4 init_req", 32'({v2, m2}), 32'h11);
    drive(4'd1, 1'b1, 1'b1);
    tick();
    chk("t4 init_resp", 32'({v2, m2}), 32'h12);
    enc_in = 4'd0;
    drive(4'd3, 1'b1, 1'b1);
    chk("t4 remote zero", 32'(rem2), 32'd0);
    tick();
    chk("t4 deg_resp", 32'({v2, m2}), 32'h14);

    // Wide mask and a stray END_RESP while waiting for INIT_RESP.
    lane_ok = 4'b1010;
    restart();
    tick();
    chk("t6 init_req", 32'({v4, m4}), 32'h11);
    drive(4'd6, 1'b1, 1'b1);
    chk("t6 stray a", 32'(v4), 32'd0);
    tick();
    chk("t6 stray b", 32'(v4), 32'd0);
    drive(4'd2, 1'b1, 1'b0);
    chk("t6 pre deg", 32'(v4), 32'd0);
    tick();
    chk("t6 deg_req", 32'({v4, m4}), 32'h13);
    chk("t6 enc4", 32'(enc4), 32'hA);
    chk("t6 enc2", 32'(enc2), 32'h2);

    // Asynchronous reset mid-sequence.
    restart();
    tick();
    chk("t7 init_req", 32'({v2, m2}), 32'h11);
    rst = 1'b1;
    #1;
    chk("t7 async valid", 32'({v2, m2}), 32'd0);
    chk("t7 async enc", 32'({enc2, enc4}), 32'd0);
    chk("t7 async ack/err", 32'({ack2, err2}), 32'd0);
    #3 rst = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
